// File: rtl/delay_cfg_deser_pkg.sv
// Shared definitions for the delay-configuration deserialiser.
//   - Geometry of the flat delay vector (keyring entries plus mul/div entries).
//   - Simulation delay constants, packed in the same order they are streamed.
//   - Receive FSM state enum.
package delay_cfg_deser_pkg;

  // Keyring is KR_E x KR_S entries, each KR_L bits wide; three further
  // entries of the same width select the mul/div delay lines.
  localparam int KR_E            = 2;
  localparam int KR_S            = 2;
  localparam int KR_L            = 4;
  localparam int KR_MD_ENTRIES   = 3;
  localparam int KEYRING_DE_FLAT = (KR_E * KR_S + KR_MD_ENTRIES) * KR_L;

  typedef logic [KEYRING_DE_FLAT-1:0] t_keyring_delay_flat;

  // Delay selections used in simulation builds. MU_DELAY_SIM occupies the
  // least significant entry, so it is the first one shifted in.
  localparam logic [KR_L-1:0] F_DELAY_SIM  = 4'd3;
  localparam logic [KR_L-1:0] G_DELAY_SIM  = 4'd5;
  localparam logic [KR_L-1:0] H_DELAY_SIM  = 4'd7;
  localparam logic [KR_L-1:0] I_DELAY_SIM  = 4'd9;
  localparam logic [KR_L-1:0] MD_DELAY_SIM = 4'd2;
  localparam logic [KR_L-1:0] DV_DELAY_SIM = 4'd11;
  localparam logic [KR_L-1:0] MU_DELAY_SIM = 4'd6;

  localparam t_keyring_delay_flat KEYRING_DELAY_SIM = {
    F_DELAY_SIM, G_DELAY_SIM, H_DELAY_SIM, I_DELAY_SIM,
    MD_DELAY_SIM, DV_DELAY_SIM, MU_DELAY_SIM
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } t_cfg_state;

endpackage

// File: rtl/delay_cfg_deser.sv
// Receive end of the serial delay-configuration chain.
// Bits arrive one per clock while i_delay_en is high and are collected in a
// shadow register. When the frame ends the bit count is checked and, if it
// is exact, the whole word is committed to o_delay_flat in one edge, so the
// delay lines downstream never see a partially loaded vector.
//
// Ports:
//   i_clk         system clock
//   i_rstn        synchronous active-low reset
//   i_delay_en    frame enable, high while configuration bits stream in
//   i_delay_cfg   serial configuration bit (first bit lands in bit 0)
//   o_delay_flat  committed delay vector
//   o_cfg_valid   set by a successful commit, cleared at reset / frame start
//   o_cfg_err     set when a frame had the wrong length, cleared likewise
//   o_busy        frame in progress (SHIFT or COMMIT)
module delay_cfg_deser
  import delay_cfg_deser_pkg::*;
#(
  parameter int                N_BITS   = KEYRING_DE_FLAT,
  parameter int                CNT_W    = $clog2(N_BITS + 1),
  parameter logic [N_BITS-1:0] RST_FLAT = '0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_delay_en,
  input  logic              i_delay_cfg,
  output logic [N_BITS-1:0] o_delay_flat,
  output logic              o_cfg_valid,
  output logic              o_cfg_err,
  output logic              o_busy
);

  t_cfg_state        r_state;
  t_cfg_state        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_BITS-1:0] r_shadow;
  logic              r_ovf;
  logic [N_BITS-1:0] r_flat;
  logic              r_valid;
  logic              r_err;
  logic              w_busy;
  logic              w_full;
  logic [N_BITS-1:0] w_bit_sel;

  assign w_full    = (r_cnt == CNT_W'(N_BITS));
  // One-hot mask of the shadow bit addressed by the counter; only used
  // while the counter is below N_BITS, so the shift never runs off the end.
  assign w_bit_sel = N_BITS'(1) << r_cnt;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. COMMIT always lasts exactly one cycle and ignores
  // i_delay_en, so a frame can only start from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_delay_en)  w_state_nxt = SHIFT;
      SHIFT:   if (!i_delay_en) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = 1'b0;
    unique case (r_state)
      SHIFT, COMMIT: w_busy = 1'b1;
      default:       w_busy = 1'b0;
    endcase
  end

  // Shadow register, bit counter and commit registers. i_delay_cfg is only
  // sampled with i_delay_en high, so an undriven line between frames never
  // reaches the shadow.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
      r_flat   <= RST_FLAT;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_delay_en) begin
            r_shadow <= N_BITS'(i_delay_cfg);
            r_cnt    <= CNT_W'(1);
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        SHIFT: begin
          if (i_delay_en) begin
            if (!w_full) begin
              r_shadow <= (r_shadow & ~w_bit_sel) | (w_bit_sel & {N_BITS{i_delay_cfg}});
              r_cnt    <= r_cnt + CNT_W'(1);
            end else begin
              // Surplus bits are dropped; the counter stays saturated and
              // the frame is rejected at commit time.
              r_ovf <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (w_full && !r_ovf) begin
            r_flat  <= r_shadow;
            r_valid <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_delay_flat = r_flat;
  assign o_cfg_valid  = r_valid;
  assign o_cfg_err    = r_err;
  assign o_busy       = w_busy;

endmodule

// File: tb/tb_delay_cfg_deser.sv
module tb_delay_cfg_deser;
  import delay_cfg_deser_pkg::*;

  localparam int                  NA    = 8;
  localparam logic [NA-1:0]       RST_A = 8'h00;
  localparam t_keyring_delay_flat RST_B = 28'h5A5_A5A5;

  logic clk;
  logic a_rstn, a_en, a_cfg;
  logic [NA-1:0] a_flat;
  logic a_valid, a_err, a_busy;
  logic b_rstn, b_en, b_cfg;
  t_keyring_delay_flat b_flat;
  logic b_valid, b_err, b_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference state (what downstream should see after a frame)
  logic [NA-1:0]       ma_flat;
  logic                ma_valid, ma_err;
  t_keyring_delay_flat mb_flat;
  logic                mb_valid, mb_err;

  delay_cfg_deser #(.N_BITS(NA), .RST_FLAT(RST_A)) u_dut_a (
    .i_clk(clk), .i_rstn(a_rstn), .i_delay_en(a_en), .i_delay_cfg(a_cfg),
    .o_delay_flat(a_flat), .o_cfg_valid(a_valid), .o_cfg_err(a_err), .o_busy(a_busy)
  );

  delay_cfg_deser #(.N_BITS(KEYRING_DE_FLAT), .RST_FLAT(RST_B)) u_dut_b (
    .i_clk(clk), .i_rstn(b_rstn), .i_delay_en(b_en), .i_delay_cfg(b_cfg),
    .o_delay_flat(b_flat), .o_cfg_valid(b_valid), .o_cfg_err(b_err), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame rule: exactly NA bits commits them (first bit -> bit 0);
  // any other length flags an error and keeps the previous value.
  task automatic a_model(input logic [15:0] bits, input int len);
    if (len == NA) begin
      ma_flat  = bits[NA-1:0];
      ma_valid = 1'b1;
      ma_err   = 1'b0;
    end else begin
      ma_valid = 1'b0;
      ma_err   = 1'b1;
    end
  endtask

  task automatic a_check_result(input string tag);
    chk({tag, "_flat"},  a_flat,  ma_flat);
    chk({tag, "_valid"}, a_valid, ma_valid);
    chk({tag, "_err"},   a_err,   ma_err);
    chk({tag, "_idle"},  a_busy,  1'b0);
  endtask

  task automatic a_stream(input logic [15:0] bits, input int first, input int len);
    logic [15:0] sh;
    for (int i = first; i < len; i++) begin
      sh    = bits >> i;
      a_en  = 1'b1;
      a_cfg = sh[0];
      tick();
      chk("a_shift_busy", a_busy, 1'b1);
      chk("a_shift_hold", a_flat, ma_flat);
      if (i == first) begin
        chk("a_start_valid_clr", a_valid, 1'b0);
        chk("a_start_err_clr",   a_err,   1'b0);
      end
    end
    a_en  = 1'b0;
    a_cfg = 1'bx;
  endtask

  // Full frame followed by a two-cycle gap; result checked on the second
  // edge after enable is first seen low.
  task automatic a_run(input string tag, input logic [15:0] bits, input int len);
    a_stream(bits, 0, len);
    tick();
    chk({tag, "_commit_busy"}, a_busy, 1'b1);
    chk({tag, "_no_early"},    a_flat, ma_flat);
    a_model(bits, len);
    tick();
    a_check_result(tag);
  endtask

  task automatic b_run(input string tag, input t_keyring_delay_flat bits, input int len);
    t_keyring_delay_flat sh;
    for (int i = 0; i < len; i++) begin
      sh    = bits >> i;
      b_en  = 1'b1;
      b_cfg = sh[0];
      tick();
    end
    b_en  = 1'b0;
    b_cfg = 1'b0;
    tick();
    tick();
    if (len == KEYRING_DE_FLAT) begin
      mb_flat  = bits;
      mb_valid = 1'b1;
      mb_err   = 1'b0;
    end else begin
      mb_valid = 1'b0;
      mb_err   = 1'b1;
    end
    chk({tag, "_flat"},  b_flat,  mb_flat);
    chk({tag, "_valid"}, b_valid, mb_valid);
    chk({tag, "_err"},   b_err,   mb_err);
    chk({tag, "_idle"},  b_busy,  1'b0);
  endtask

  initial begin
    logic [15:0] rbits;
    logic [15:0] sh;
    int          rlen;

    a_rstn = 1'b0; a_en = 1'b0; a_cfg = 1'b0;
    b_rstn = 1'b0; b_en = 1'b0; b_cfg = 1'b0;
    ma_flat = RST_A; ma_valid = 1'b0; ma_err = 1'b0;
    mb_flat = RST_B; mb_valid = 1'b0; mb_err = 1'b0;
    tick();
    tick();
    a_rstn = 1'b1;
    b_rstn = 1'b1;
    a_cfg  = 1'bx;

    // Reset state
    a_check_result("a_reset");
    chk("b_reset_flat",  b_flat,  RST_B);
    chk("b_reset_valid", b_valid, 1'b0);
    chk("b_reset_busy",  b_busy,  1'b0);

    // Nominal frame: 1,0,1,1,0,0,0,1
    a_run("nominal", 16'h008D, 8);
    chk("nominal_const", a_flat, 8'h8D);

    // Short frame keeps 8'h8D
    a_run("short", 16'h0015, 5);
    chk("short_const", a_flat, 8'h8D);

    // Long frame: eight ones then two zeros
    a_run("long", 16'h00FF, 10);
    chk("long_const", a_flat, 8'h8D);
    a_run("zeros", 16'h0000, 8);

    // Reset in the middle of a frame
    a_run("pre_rst", 16'h00C3, 8);
    a_stream(16'h000F, 0, 4);
    a_en   = 1'b1;
    a_cfg  = 1'b1;
    a_rstn = 1'b0;
    tick();
    ma_flat = RST_A; ma_valid = 1'b0; ma_err = 1'b0;
    a_check_result("mid_rst");
    a_rstn = 1'b1;
    a_en   = 1'b0;
    a_cfg  = 1'bx;
    tick();
    a_run("post_rst", 16'h0096, 8);

    // Back-to-back with a one-cycle gap: first bit of the second frame
    // arrives during COMMIT and is dropped, leaving a 7-bit frame.
    a_stream(16'h00A5, 0, 8);
    tick();
    sh    = 16'h003C;
    a_en  = 1'b1;
    a_cfg = sh[0];
    a_model(16'h00A5, 8);
    tick();
    a_check_result("b2b1_first");
    chk("b2b1_first_const", a_flat, 8'hA5);
    a_stream(16'h003C, 1, 8);
    tick();
    tick();
    a_model(16'h001E, 7);
    a_check_result("b2b1_second");
    chk("b2b1_second_err", a_err, 1'b1);

    // Two-cycle gap: both frames commit
    a_run("b2b2_first", 16'h00A5, 8);
    a_run("b2b2_second", 16'h003C, 8);
    chk("b2b2_const", a_flat, 8'h3C);

    // Randomized frames, mostly legal length
    for (int f = 0; f < 24; f++) begin
      rbits = 16'($urandom);
      if ($urandom_range(0, 2) != 0) rlen = 8;
      else                           rlen = int'($urandom_range(1, 12));
      a_run("rand", rbits, rlen);
    end

    // Full-width configuration
    b_run("full", KEYRING_DELAY_SIM, KEYRING_DE_FLAT);
    chk("full_const", b_flat, KEYRING_DELAY_SIM);
    b_run("full_short", ~KEYRING_DELAY_SIM, KEYRING_DE_FLAT - 1);
    chk("full_short_keep", b_flat, KEYRING_DELAY_SIM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
